// File: rtl/instr_sequencer_if.sv
// Handshake and strobe bundle between the instruction sequencer and the datapath.
// master: the sequencer side; slave: the datapath / memory side.
interface instr_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       instr_i;
    logic             imem_ready_i;
    logic             dmem_ready_i;
    logic             alu_done_i;
    logic             cond_i;
    logic             resume_i;
    logic             imem_req_o;
    logic             ir_we_o;
    logic             pc_we_o;
    logic             pc_sel_o;
    logic             reg_we_o;
    logic             flags_we_o;
    logic             dmem_re_o;
    logic             dmem_we_o;
    logic             alu_start_o;
    logic             busy_o;
    logic             retire_o;
    logic [CNT_W-1:0] retired_o;
    logic             err_o;

    modport master (
        input  instr_i, imem_ready_i, dmem_ready_i, alu_done_i, cond_i, resume_i,
        output imem_req_o, ir_we_o, pc_we_o, pc_sel_o, reg_we_o, flags_we_o,
               dmem_re_o, dmem_we_o, alu_start_o, busy_o, retire_o, retired_o, err_o
    );

    modport slave (
        output instr_i, imem_ready_i, dmem_ready_i, alu_done_i, cond_i, resume_i,
        input  imem_req_o, ir_we_o, pc_we_o, pc_sel_o, reg_we_o, flags_we_o,
               dmem_re_o, dmem_we_o, alu_start_o, busy_o, retire_o, retired_o, err_o
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch / decode / execute / memory-wait /
// ALU-wait / wait-for-event, with strobe generation and a retired-instruction count.
// Strobes are decodes of the state, the latched IR and the handshake inputs.
// Opcode map {op,inst}: 00_00 SAL, 00_11 SIG, 00_01/00_10 NOP, 01_xx ESP,
// 10_00 GDR, 10_01 CAR, 10_10 MOVR/MOVI, 10_11 CMPR/CMPI,
// 11_00 SUM/DDR, 11_01 RES, 11_10 MOD, 11_11 MUL; imm only steers the datapath.
// Optional macro SEQ_TIMEOUT_EN adds a wait watchdog that parks the block in ERR.
module instr_sequencer #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst_n,
    instr_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEMWAIT, ALUWAIT, WAITEV, ERR
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       ir_q;
    logic [CNT_W-1:0] retired_q;
    logic [1:0]       op, inst;
    logic             imm_unused;
    logic             is_mem, is_mul, is_esp;
    logic             timeout_c;
    logic             imem_req_c, ir_we_c, pc_we_c, pc_sel_c, reg_we_c, flags_we_c;
    logic             dmem_re_c, dmem_we_c, alu_start_c, retire_c;

    assign op         = ir_q[4:3];
    assign inst       = ir_q[2:1];
    assign imm_unused = ir_q[0];
    assign is_mem     = (op == 2'b10) && !inst[1];
    assign is_mul     = (op == 2'b11) && inst[1];
    assign is_esp     = (op == 2'b01);

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] wait_cnt_q;
    logic            counting_c;

    assign counting_c = (state_q == FETCH) || (state_q == MEMWAIT) || (state_q == ALUWAIT);

    // Wait-cycle counter; restarts whenever the state changes, idle outside bounded waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if ((state_d != state_q) || !counting_c) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
        end
    end

    assign timeout_c = counting_c && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign bus.err_o = (state_q == ERR);
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
    assign timeout_c = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register, loaded on the accepted fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (ir_we_c) begin
            ir_q <= bus.instr_i;
        end
    end

    // Retired-instruction counter, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire_c) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d     = state_q;
        imem_req_c  = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_sel_c    = 1'b0;
        reg_we_c    = 1'b0;
        flags_we_c  = 1'b0;
        dmem_re_c   = 1'b0;
        dmem_we_c   = 1'b0;
        alu_start_c = 1'b0;
        retire_c    = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready_i) begin
                    ir_we_c = 1'b1;
                    state_d = DECODE;
                end else if (timeout_c) begin
                    state_d = ERR;
                end
            end
            DECODE: begin
                if (is_mem) begin
                    state_d = MEMWAIT;
                end else if (is_esp) begin
                    state_d = WAITEV;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_mul) begin
                    alu_start_c = 1'b1;
                    state_d     = ALUWAIT;
                end else begin
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                    case (op)
                        2'b00: begin
                            if (inst == 2'b00) begin
                                pc_sel_c = 1'b1;
                            end else if (inst == 2'b11) begin
                                pc_sel_c = bus.cond_i;
                            end
                        end
                        2'b10: begin
                            reg_we_c   = (inst == 2'b10);
                            flags_we_c = (inst == 2'b11);
                        end
                        2'b11: reg_we_c = 1'b1;
                        default: ;
                    endcase
                end
            end
            MEMWAIT: begin
                dmem_re_c = inst[0];
                dmem_we_c = !inst[0];
                if (bus.dmem_ready_i) begin
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    reg_we_c = inst[0];
                    state_d  = FETCH;
                end else if (timeout_c) begin
                    state_d = ERR;
                end
            end
            ALUWAIT: begin
                if (bus.alu_done_i) begin
                    reg_we_c = 1'b1;
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (timeout_c) begin
                    state_d = ERR;
                end
            end
            WAITEV: begin
                if (bus.resume_i) begin
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            ERR: state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req_o  = imem_req_c;
    assign bus.ir_we_o     = ir_we_c;
    assign bus.pc_we_o     = pc_we_c;
    assign bus.pc_sel_o    = pc_sel_c;
    assign bus.reg_we_o    = reg_we_c;
    assign bus.flags_we_o  = flags_we_c;
    assign bus.dmem_re_o   = dmem_re_c;
    assign bus.dmem_we_o   = dmem_we_c;
    assign bus.alu_start_o = alu_start_c;
    assign bus.retire_o    = retire_c;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.retired_o   = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-instruction timelines built from the
// instruction-class rules, random handshake delays and random noise on
// every input the current phase should ignore.
module tb_instr_sequencer;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MOD = 1 << CNT_W;
    localparam int unsigned TO      = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int unsigned exp_retired = 0;

    always #5 clk = ~clk;

    instr_sequencer_if #(.CNT_W(CNT_W)) bus ();

    instr_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {req, ir_we, pc_we, pc_sel&pc_we, reg_we, flags_we, re, we, alu_start, retire, busy, err}
    function automatic logic [11:0] obs();
        return {bus.imem_req_o, bus.ir_we_o, bus.pc_we_o, bus.pc_sel_o & bus.pc_we_o,
                bus.reg_we_o, bus.flags_we_o, bus.dmem_re_o, bus.dmem_we_o,
                bus.alu_start_o, bus.retire_o, bus.busy_o, bus.err_o};
    endfunction

    function automatic logic [11:0] mk(input bit req, input bit irwe, input bit pcwe,
                                       input bit pcsel, input bit regwe, input bit flwe,
                                       input bit re, input bit we, input bit as,
                                       input bit ret, input bit busy, input bit err);
        return {req, irwe, pcwe, pcsel, regwe, flwe, re, we, as, ret, busy, err};
    endfunction

    // Single-cycle instruction retire vector from the instruction-class table
    function automatic logic [11:0] exec_exp(input logic [1:0] op, input logic [1:0] inst, input bit c);
        bit rw, fw, ps;
        rw = (op == 2'b11) || (op == 2'b10 && inst == 2'b10);
        fw = (op == 2'b10 && inst == 2'b11);
        ps = (op == 2'b00 && inst == 2'b00) || (op == 2'b00 && inst == 2'b11 && c);
        return mk(0, 0, 1, ps, rw, fw, 0, 0, 0, 1, 1, 0);
    endfunction

    task automatic noise();
        bus.instr_i      = 5'($urandom);
        bus.imem_ready_i = 1'($urandom);
        bus.dmem_ready_i = 1'($urandom);
        bus.alu_done_i   = 1'($urandom);
        bus.cond_i       = 1'($urandom);
        bus.resume_i     = 1'($urandom);
    endtask

    task automatic cyc(input string tag, input logic [11:0] e);
        #1;
        chk(tag, 32'(obs()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [4:0] instr, input int fw);
        for (int i = 0; i <= fw; i++) begin
            noise();
            bus.imem_ready_i = (i == fw);
            if (i == fw) bus.instr_i = instr;
            cyc("fetch", mk(1, i == fw, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        end
        noise();
        cyc("decode", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    endtask

    // One instruction, entered in FETCH; cmode 0/1 forces cond_i, 2 leaves it random
    task automatic run_instr(input logic [4:0] instr, input int fw, input int wd, input int cmode);
        logic [1:0] op, inst;
        bit last;
        op   = instr[4:3];
        inst = instr[2:1];
        chk("retired_count", 32'(bus.retired_o), exp_retired % CNT_MOD);
        fetch(instr, fw);
        if (op == 2'b10 && !inst[1]) begin
            for (int j = 0; j <= wd; j++) begin
                last = (j == wd);
                noise();
                bus.dmem_ready_i = last;
                cyc("memwait", mk(0, 0, last, 0, last && inst[0], 0, inst[0], !inst[0], 0, last, 1, 0));
            end
        end else if (op == 2'b01) begin
            for (int j = 0; j <= wd; j++) begin
                last = (j == wd);
                noise();
                bus.resume_i = last;
                cyc("waitev", mk(0, 0, last, 0, 0, 0, 0, 0, 0, last, 1, 0));
            end
        end else if (op == 2'b11 && inst[1]) begin
            noise();
            cyc("alu_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
            for (int j = 0; j <= wd; j++) begin
                last = (j == wd);
                noise();
                bus.alu_done_i = last;
                cyc("aluwait", mk(0, 0, last, 0, last, 0, 0, 0, 0, last, 1, 0));
            end
        end else begin
            noise();
            if (cmode < 2) bus.cond_i = cmode[0];
            cyc("exec", exec_exp(op, inst, bus.cond_i));
        end
        exp_retired++;
    endtask

    task automatic do_reset(input string tag);
        noise();
        rst_n = 1'b0;
        #1;
        chk({tag, "_outputs"}, 32'(obs()), 32'd0);
        chk({tag, "_retired"}, 32'(bus.retired_o), 32'd0);
        exp_retired = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        noise();
        cyc({tag, "_idle"}, 12'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] ins;
        rst_n = 1'b0;
        noise();
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        run_instr(5'b11000, 0, 0, 2);   // SUM
        run_instr(5'b10010, 0, 4, 2);   // CAR, ready after 4 wait cycles
        run_instr(5'b11110, 0, 6, 2);   // MUL, done after 6 wait cycles
        run_instr(5'b00111, 0, 0, 0);   // SIG cond=0
        run_instr(5'b00111, 0, 0, 1);   // SIG cond=1
        run_instr(5'b00001, 0, 0, 2);   // SAL
        run_instr(5'b10000, 2, 3, 2);   // GDR
        run_instr(5'b10111, 1, 0, 2);   // CMPI
        run_instr(5'b01000, 0, 10, 2);  // ESP, resume after 10 cycles

        for (int k = 0; k < 300; k++) begin
            ins = 5'($urandom);
            run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 2);
        end

        if (exp_retired % CNT_MOD == 0) run_instr(5'b11000, 0, 0, 2);
        chk("retired_before_abort", 32'(bus.retired_o), exp_retired % CNT_MOD);
        fetch(5'b01000, 0);
        for (int j = 0; j < 3; j++) begin
            noise();
            bus.resume_i = 1'b0;
            cyc("waitev_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        end
        do_reset("abort_waitev");
        run_instr(5'b11001, 0, 0, 2);
        chk("retired_after_abort", 32'(bus.retired_o), exp_retired % CNT_MOD);

`ifdef SEQ_TIMEOUT_EN
        fetch(5'b10000, 0);
        for (int j = 0; j < int'(TO); j++) begin
            noise();
            bus.dmem_ready_i = 1'b0;
            cyc("memwait_stall", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        end
        for (int j = 0; j < 5; j++) begin
            noise();
            cyc("err_sticky", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        end
        do_reset("err_clear");
        run_instr(5'b11000, 0, 0, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
